// File: rtl/gcd_job_arbiter_if.sv
// rtl/gcd_job_arbiter_if.sv - requester and GCD engine signal bundle for gcd_job_arbiter
interface gcd_job_arbiter_if #(
   parameter int NREQ = 4,
   parameter int W    = 3
);
   // requester side
   logic [NREQ-1:0]   req;
   logic [NREQ*W-1:0] a_in;
   logic [NREQ*W-1:0] b_in;
   logic [NREQ-1:0]   gnt;
   logic [NREQ-1:0]   done;
   logic [W-1:0]      result;
   logic              err;

   // engine side
   logic              eng_start;
   logic              eng_reset;
   logic [W-1:0]      eng_ain;
   logic [W-1:0]      eng_bin;
   logic [W-1:0]      eng_out;
   logic              eng_valid;

   // requesters plus engine, as seen from outside the arbiter
   modport master (
      output req, a_in, b_in, eng_out, eng_valid,
      input  gnt, done, result, err, eng_start, eng_reset, eng_ain, eng_bin
   );

   // the arbiter itself
   modport slave (
      input  req, a_in, b_in, eng_out, eng_valid,
      output gnt, done, result, err, eng_start, eng_reset, eng_ain, eng_bin
   );
endinterface

// File: rtl/gcd_job_arbiter.sv
// rtl/gcd_job_arbiter.sv - round-robin sharing of one subtractive GCD engine between NREQ requesters
module gcd_job_arbiter #(
   parameter int NREQ    = 4,
   parameter int W       = 3,
   parameter int TIMEOUT = 32
) (
   input  logic            clk,
   input  logic            reset,
   gcd_job_arbiter_if.slave bus
);
   localparam int IW  = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int WDW = $clog2(TIMEOUT + 1);

   localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);
   localparam logic [WDW-1:0] WD_MAX  = {WDW{1'b1}};
   localparam logic [IW-1:0]  IDX_TOP = IW'(NREQ - 1);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_LAUNCH = 3'd1;
   localparam logic [2:0] S_WAIT   = 3'd2;
   localparam logic [2:0] S_BYPASS = 3'd3;
   localparam logic [2:0] S_DONE   = 3'd4;

   logic [2:0]     state;
   logic [IW-1:0]  rr;
   logic [IW-1:0]  idx;
   logic [W-1:0]   op_a;
   logic [W-1:0]   op_b;
   logic [WDW-1:0] wdog;

   logic [NREQ-1:0] gnt_q;
   logic [NREQ-1:0] done_q;
   logic [W-1:0]    result_q;
   logic            err_q;
   logic            eng_start_q;
   logic            eng_reset_q;
   logic [W-1:0]    eng_ain_q;
   logic [W-1:0]    eng_bin_q;

   logic            pick_valid;
   logic [IW-1:0]   pick_idx;
   logic [IW:0]     cand;
   logic [W-1:0]    pick_a;
   logic [W-1:0]    pick_b;
   logic            pick_zero;

   assign bus.gnt       = gnt_q;
   assign bus.done      = done_q;
   assign bus.result    = result_q;
   assign bus.err       = err_q;
   assign bus.eng_start = eng_start_q;
   assign bus.eng_reset = eng_reset_q;
   assign bus.eng_ain   = eng_ain_q;
   assign bus.eng_bin   = eng_bin_q;

   // Round-robin pick: scan from the farthest candidate back to rr so the
   // first active requester at or after rr (wrapping) is the one that sticks.
   always_comb begin
      pick_valid = 1'b0;
      pick_idx   = '0;
      cand       = '0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         cand = {1'b0, rr} + (IW+1)'(i);
         if (cand >= (IW+1)'(NREQ)) begin
            cand = cand - (IW+1)'(NREQ);
         end
         if (bus.req[cand[IW-1:0]]) begin
            pick_valid = 1'b1;
            pick_idx   = cand[IW-1:0];
         end
      end
   end

   // Operand mux for the picked requester; zero operands are routed around the engine.
   always_comb begin
      pick_a = '0;
      pick_b = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (pick_idx == IW'(i)) begin
            pick_a = bus.a_in[i*W +: W];
            pick_b = bus.b_in[i*W +: W];
         end
      end
      pick_zero = (pick_a == '0) || (pick_b == '0);
   end

   // Job FSM with registered outputs; pulses default low every cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= S_IDLE;
         rr          <= '0;
         idx         <= '0;
         op_a        <= '0;
         op_b        <= '0;
         wdog        <= '0;
         gnt_q       <= '0;
         done_q      <= '0;
         result_q    <= '0;
         err_q       <= 1'b0;
         eng_start_q <= 1'b0;
         eng_reset_q <= 1'b1;
         eng_ain_q   <= '0;
         eng_bin_q   <= '0;
      end else begin
         eng_start_q <= 1'b0;
         eng_reset_q <= 1'b0;
         done_q      <= '0;
         err_q       <= 1'b0;
         case (state)
            S_IDLE: begin
               if (pick_valid) begin
                  gnt_q           <= '0;
                  gnt_q[pick_idx] <= 1'b1;
                  idx             <= pick_idx;
                  op_a            <= pick_a;
                  op_b            <= pick_b;
                  if (pick_zero) begin
                     state <= S_BYPASS;
                  end else begin
                     // start is presented during the LAUNCH cycle together with the operands
                     state       <= S_LAUNCH;
                     eng_start_q <= 1'b1;
                     eng_ain_q   <= pick_a;
                     eng_bin_q   <= pick_b;
                  end
               end
            end
            S_LAUNCH: begin
               wdog  <= '0;
               state <= S_WAIT;
            end
            S_WAIT: begin
               wdog <= (wdog == WD_MAX) ? wdog : wdog + WDW'(1);
               if (bus.eng_valid) begin
                  // engine drops valid on the start edge, so a high valid here is this job's
                  result_q    <= bus.eng_out;
                  done_q[idx] <= 1'b1;
                  state       <= S_DONE;
               end else if (wdog == WD_LAST) begin
                  result_q    <= '0;
                  err_q       <= 1'b1;
                  eng_reset_q <= 1'b1;
                  done_q[idx] <= 1'b1;
                  state       <= S_DONE;
               end
            end
            S_BYPASS: begin
               // gcd(x,0) = x and gcd(0,0) = 0, so OR gives the answer directly
               result_q    <= op_a | op_b;
               done_q[idx] <= 1'b1;
               state       <= S_DONE;
            end
            S_DONE: begin
               gnt_q    <= '0;
               result_q <= '0;
               rr       <= (idx == IDX_TOP) ? '0 : idx + IW'(1);
               state    <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end
endmodule
